// File: rtl/imem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. loader/debug) for a single-port
// instruction RAM with 1-cycle registered read, starvation guard and address checks.
module imem_arbiter #(
  parameter int MEM_WORDS  = 512,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        l_err,
  output logic        m_en,
  output logic        m_we,
  output logic [8:0]  m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, RESP_F, RESP_L} state_t;

  state_t     state, state_next;
  logic [2:0] starve_cnt, starve_next;
  logic       err_reg, err_next;
  logic       wdrop_reg, wdrop_next;
  logic       pick_f, pick_l, sel_ill;

  function automatic logic addr_illegal(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(MEM_WORDS));
  endfunction

  // Request side is purely combinational; reset overrides every grant.
  always_comb begin
    pick_f      = 1'b0;
    pick_l      = 1'b0;
    sel_ill     = 1'b0;
    f_gnt       = 1'b0;
    l_gnt       = 1'b0;
    m_en        = 1'b0;
    m_we        = 1'b0;
    m_addr      = f_addr[10:2];
    m_wdata     = l_wdata;
    state_next  = IDLE;
    err_next    = 1'b0;
    wdrop_next  = 1'b0;
    starve_next = starve_cnt;
    if (!rst) begin
      pick_f = f_req && !(l_req && (starve_cnt == 3'(STARVE_MAX)));
      pick_l = l_req && !pick_f;
      if (pick_l) begin
        sel_ill = addr_illegal(l_addr);
        m_addr  = l_addr[10:2];
      end else if (pick_f) begin
        sel_ill = addr_illegal(f_addr);
      end
      f_gnt = pick_f;
      l_gnt = pick_l;
      m_en  = (pick_f || pick_l) && !sel_ill;
      m_we  = pick_l && l_we && !sel_ill;
      if (pick_f) begin
        state_next = RESP_F;
        err_next   = sel_ill;
      end else if (pick_l && !l_we) begin
        state_next = RESP_L;
        err_next   = sel_ill;
      end
      wdrop_next = pick_l && l_we && sel_ill;
      // Starvation counter saturates so the loader wins once it reaches the limit.
      if (!l_req || pick_l)
        starve_next = 3'd0;
      else if (pick_f && (starve_cnt < 3'(STARVE_MAX)))
        starve_next = starve_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      err_reg    <= 1'b0;
      wdrop_reg  <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      err_reg    <= err_next;
      wdrop_reg  <= wdrop_next;
    end
  end

  // Response side: data straight from the RAM, zeroed for errors and idle cycles.
  always_comb begin
    f_rvalid = (state == RESP_F);
    l_rvalid = (state == RESP_L);
    f_err    = f_rvalid && err_reg;
    l_err    = (l_rvalid && err_reg) || wdrop_reg;
    f_rdata  = (f_rvalid && !err_reg) ? m_rdata : 32'd0;
    l_rdata  = (l_rvalid && !err_reg) ? m_rdata : 32'd0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: behavioural RAM on the memory port, a
// spec-level model checked every cycle, plus literal expectations per scenario.
module tb_imem_arbiter;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [31:0] f_addr = '0, l_addr = '0, l_wdata = '0;
  logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err, m_en, m_we;
  logic [31:0] f_rdata, l_rdata, m_wdata, m_rdata;
  logic [8:0]  m_addr;

  int checks = 0;
  int errors = 0;

  imem_arbiter #(.MEM_WORDS(512), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural instruction RAM with registered read.
  logic [31:0] ram [512];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) ram[m_addr] <= m_wdata;
      else      m_rdata     <= ram[m_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level model: expected memory contents, one pending response, starvation count.
  logic [31:0] shadow [512];
  int          starve = 0;
  bit          pend_f = 0, pend_l = 0, pend_err = 0, pend_drop = 0;
  logic [31:0] pend_data = '0;

  function automatic bit illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 512);
  endfunction

  always @(negedge clk) begin
    bit          ef, el, ill, wr;
    logic [31:0] a;
    if (rst) begin
      chk("rst f_gnt", {31'd0, f_gnt}, 0);
      chk("rst l_gnt", {31'd0, l_gnt}, 0);
      chk("rst m_en", {31'd0, m_en}, 0);
      chk("rst f_rvalid", {31'd0, f_rvalid}, 0);
      chk("rst l_err", {31'd0, l_err}, 0);
      chk("rst f_rdata", f_rdata, 0);
      starve = 0; pend_f = 0; pend_l = 0; pend_err = 0; pend_drop = 0;
    end else begin
      ef  = f_req && !(l_req && starve == SM);
      el  = l_req && !ef;
      a   = el ? l_addr : f_addr;
      ill = (ef || el) && illegal(a);
      wr  = el && l_we;
      chk("m f_gnt", {31'd0, f_gnt}, {31'd0, ef});
      chk("m l_gnt", {31'd0, l_gnt}, {31'd0, el});
      chk("m m_en", {31'd0, m_en}, {31'd0, (ef || el) && !ill});
      chk("m m_we", {31'd0, m_we}, {31'd0, wr && !ill});
      if ((ef || el) && !ill) chk("m m_addr", {23'd0, m_addr}, (a / 4) % 512);
      if (wr && !ill) chk("m m_wdata", m_wdata, l_wdata);
      chk("m f_rvalid", {31'd0, f_rvalid}, {31'd0, pend_f});
      chk("m f_rdata", f_rdata, pend_f ? pend_data : 32'd0);
      chk("m f_err", {31'd0, f_err}, {31'd0, pend_f && pend_err});
      chk("m l_rvalid", {31'd0, l_rvalid}, {31'd0, pend_l});
      chk("m l_rdata", l_rdata, pend_l ? pend_data : 32'd0);
      chk("m l_err", {31'd0, l_err}, {31'd0, (pend_l && pend_err) || pend_drop});
      pend_f    = ef;
      pend_l    = el && !l_we;
      pend_err  = ill;
      pend_drop = wr && ill;
      pend_data = ill ? 32'd0 : shadow[(a / 4) % 512];
      if (wr && !ill) shadow[(a / 4) % 512] = l_wdata;
      if (!l_req || el) starve = 0;
      else if (ef && starve < SM) starve++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]    = 32'h1000_0000 + 32'(i * 7);
      shadow[i] = 32'h1000_0000 + 32'(i * 7);
    end
    ram[0] = 32'h2004_0005; shadow[0] = 32'h2004_0005;
    ram[1] = 32'h2008_0080; shadow[1] = 32'h2008_0080;

    // Reset holds grants low even with requests present.
    cyc(); f_req = 1; l_req = 1; #1;
    chk("reset f_gnt", {31'd0, f_gnt}, 0);
    chk("reset m_en", {31'd0, m_en}, 0);
    cyc(); f_req = 0; l_req = 0; rst = 0;
    cyc();

    // Single fetch of word 1.
    f_req = 1; f_addr = 32'h4; #1;
    chk("fetch f_gnt", {31'd0, f_gnt}, 1);
    chk("fetch m_addr", {23'd0, m_addr}, 1);
    cyc(); f_req = 0; #1;
    chk("fetch f_rvalid", {31'd0, f_rvalid}, 1);
    chk("fetch f_rdata", f_rdata, 32'h2008_0080);
    chk("fetch f_err", {31'd0, f_err}, 0);
    cyc();

    // Back-to-back fetches, then reset during the second response.
    f_req = 1; f_addr = 32'h0;
    cyc(); f_addr = 32'h4; #1;
    chk("b2b rdata0", f_rdata, 32'h2004_0005);
    cyc(); f_req = 0; #1;
    chk("b2b rvalid1", {31'd0, f_rvalid}, 1);
    chk("b2b rdata1", f_rdata, 32'h2008_0080);
    rst = 1; #1;
    chk("rst drops rvalid", {31'd0, f_rvalid}, 0);
    chk("rst drops rdata", f_rdata, 0);
    cyc(); rst = 0;
    cyc();
    chk("idle after rst", {31'd0, f_rvalid}, 0);

    // Starvation: loader wins every fifth cycle while both request.
    f_req = 1; l_req = 1; l_we = 0; f_addr = 32'hC; l_addr = 32'h8;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk($sformatf("starve l_gnt c%0d", k), {31'd0, l_gnt}, {31'd0, (k % 5) == 0});
      chk($sformatf("starve f_gnt c%0d", k), {31'd0, f_gnt}, {31'd0, (k % 5) != 0});
      cyc();
    end
    f_req = 0; l_req = 0;
    cyc();

    // Loader write then fetch of the same address.
    l_req = 1; l_we = 1; l_addr = 32'h2D4; l_wdata = 32'hDEAD_BEEF; #1;
    chk("wr l_gnt", {31'd0, l_gnt}, 1);
    chk("wr m_addr", {23'd0, m_addr}, 9'h0B5);
    cyc(); l_req = 0; l_we = 0; f_req = 1; f_addr = 32'h2D4; #1;
    chk("wr no l_rvalid", {31'd0, l_rvalid}, 0);
    cyc(); f_req = 0; #1;
    chk("raw f_rdata", f_rdata, 32'hDEAD_BEEF);
    cyc();

    // Illegal fetch (misaligned).
    f_req = 1; f_addr = 32'h802; #1;
    chk("ill f m_en", {31'd0, m_en}, 0);
    chk("ill f_gnt", {31'd0, f_gnt}, 1);
    cyc(); f_req = 0; #1;
    chk("ill f_rvalid", {31'd0, f_rvalid}, 1);
    chk("ill f_rdata", f_rdata, 0);
    chk("ill f_err", {31'd0, f_err}, 1);
    cyc();

    // Illegal loader write (out of range) is dropped with an error pulse.
    l_req = 1; l_we = 1; l_addr = 32'h1000; l_wdata = 32'h5555_AAAA; #1;
    chk("ill w l_gnt", {31'd0, l_gnt}, 1);
    chk("ill w m_en", {31'd0, m_en}, 0);
    cyc(); l_req = 0; l_we = 0; #1;
    chk("ill w l_err", {31'd0, l_err}, 1);
    chk("ill w l_rvalid", {31'd0, l_rvalid}, 0);
    cyc();
    chk("ill w l_err clr", {31'd0, l_err}, 0);
    chk("ill w ram0", ram[0], 32'h2004_0005);

    // Loader reads: legal then illegal.
    l_req = 1; l_addr = 32'h4;
    cyc(); l_addr = 32'h3; #1;
    chk("l rd l_rdata", l_rdata, 32'h2008_0080);
    chk("l rd l_err", {31'd0, l_err}, 0);
    cyc(); l_req = 0; #1;
    chk("l ill l_rvalid", {31'd0, l_rvalid}, 1);
    chk("l ill l_err", {31'd0, l_err}, 1);
    chk("l ill l_rdata", l_rdata, 0);
    cyc();

    // Short mixed sequence, checked by the model only.
    for (int k = 0; k < 24; k++) begin
      f_req   = k[0];
      l_req   = (k % 3) != 0;
      l_we    = (k % 4) == 1;
      f_addr  = 32'(k * 4);
      l_addr  = (k == 7) ? 32'h0000_0801 : 32'(k * 8);
      l_wdata = 32'hA5A5_0000 + 32'(k);
      cyc();
    end
    f_req = 0; l_req = 0; l_we = 0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 512: number of 32-bit instruction words; word index = addr[10:2].
REQ-002 SHALL have parameter STARVE_MAX, default 4: maximum consecutive fetch grants while the loader waits.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports f_req in 1 / f_addr in 32: fetch read request and byte address.
REQ-006 SHALL have ports f_gnt out 1 / f_rvalid out 1 / f_rdata out 32 / f_err out 1: fetch grant, response valid, data, error.
REQ-007 SHALL have ports l_req in 1 / l_we in 1 / l_addr in 32 / l_wdata in 32: loader/debug request, write enable, byte address, write data.
REQ-008 SHALL have ports l_gnt out 1 / l_rvalid out 1 / l_rdata out 32 / l_err out 1: loader grant, read response valid, data, error.
REQ-009 SHALL have ports m_en out 1 / m_we out 1 / m_addr out 9 / m_wdata out 32 / m_rdata in 32: memory port; m_rdata is valid one cycle after m_en with m_we=0.

Function
REQ-010 SHALL be combinational on the request side: f_gnt, l_gnt, m_en, m_we, m_addr and m_wdata depend only on the current requests and the starvation counter.
REQ-011 SHALL grant at most one requester per cycle; with no request, both grants and m_en are 0.
REQ-012 SHALL grant fetch by default when both request, unless starve_cnt == STARVE_MAX, in which case the loader is granted.
REQ-013 SHALL maintain starve_cnt (3 bits):
- increment when l_req=1 and f_gnt=1;
- clear when l_gnt=1 or l_req=0;
- saturate at STARVE_MAX.
REQ-014 SHALL treat a request as illegal when:
- addr[1:0] != 0; or
- addr[31:11] != 0 (i.e. word index >= MEM_WORDS).
REQ-015 SHALL handle an illegal request as follows:
- grant it, with m_en=0 and m_we=0;
- reads: rvalid=1, rdata=0, err=1 one cycle later;
- writes: dropped; l_err pulses one cycle later.
REQ-016 SHALL drive, for a legal granted request: m_en=1, m_addr=addr[10:2], m_we=l_we for a loader grant and 0 for a fetch grant, m_wdata=l_wdata.
REQ-017 SHALL track the outstanding response in a registered state machine:
- states IDLE, RESP_F, RESP_L;
- next state RESP_F on a fetch read grant, RESP_L on a loader read grant, otherwise IDLE;
- every state can reach any state in one cycle, so back-to-back reads are accepted every cycle.
REQ-018 SHALL, in RESP_F, assert f_rvalid=1 with f_rdata=m_rdata; in RESP_L, assert l_rvalid=1 with l_rdata=m_rdata; rdata is 0 when the matching rvalid is 0.
REQ-019 SHALL give read latency of exactly 1 cycle from grant to rvalid.
REQ-020 SHALL make loader writes produce no rvalid and take effect before the next cycle's read, so a write followed next cycle by a read of the same address returns the new data.
REQ-021 SHALL keep err asserted only together with the matching rvalid, or on the write-drop pulse.

Reset
REQ-022 SHALL, while rst=1 asynchronously:
- force state to IDLE and starve_cnt to 0;
- force all rvalid, err and rdata outputs to 0;
- force f_gnt, l_gnt, m_en and m_we to 0, regardless of requests.
REQ-023 SHALL discard a response pending when reset asserts; after rst deasserts, the first grant occurs on the first cycle with a request.

Verification
REQ-024 SHALL verify single fetch: f_req=1, f_addr=0x0000_0004, memory word 1 = 0x2008_0080 -> f_gnt=1 and m_addr=1 the same cycle; f_rvalid=1, f_rdata=0x2008_0080, f_err=0 the next cycle.
REQ-025 SHALL verify starvation: f_req and l_req held high with STARVE_MAX=4 -> fetch granted 4 cycles, loader granted in cycle 5, fetch granted in cycle 6, starve_cnt=0 after cycle 5.
REQ-026 SHALL verify write then read: loader write to 0x0000_02D4 with data 0xDEAD_BEEF, then a fetch of 0x0000_02D4 the next cycle -> no l_rvalid; f_rdata=0xDEAD_BEEF.
REQ-027 SHALL verify illegal addresses:
- fetch of 0x0000_0802 -> m_en=0; next cycle f_rvalid=1, f_rdata=0, f_err=1;
- loader write to 0x0000_1000 -> memory unchanged, l_err pulse.
REQ-028 SHALL verify back-to-back and reset: fetch reads of word 0 then word 1 on consecutive cycles -> f_rvalid high 2 cycles with 0x2004_0005 then 0x2008_0080; rst asserted during the second response cycle -> f_rvalid drops immediately, state IDLE.
